// File: rtl/simon_round_engine.sv
// Iterative Simon 128/128 engine: one round plus one key-schedule step per clock.
// Decryption expands the key schedule forward first, then unwinds it round by round.
module simon_round_engine #(
  parameter int NR = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         encrypt_i,
  input  logic [127:0] pt_i,
  input  logic [127:0] k0_i,
  output logic         valid_o,
  output logic [127:0] ct_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] KEXP = 3'd1;
  localparam logic [2:0] ENC  = 3'd2;
  localparam logic [2:0] DEC  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [63:0] C      = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [61:0] Z2     = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [6:0]  LAST   = 7'(NR - 1);
  localparam logic [6:0]  KLAST  = 7'(NR - 3);

  logic [2:0]  state;
  logic [6:0]  i;
  logic [63:0] x;
  logic [63:0] y;
  logic [63:0] ka;
  logic [63:0] kb;

  logic [63:0] enc_x;
  logic [63:0] dec_y;
  logic [63:0] k_fwd;
  logic [63:0] k_inv;

  function automatic logic [63:0] f_round(input logic [63:0] v);
    return ({v[62:0], v[63]} & {v[55:0], v[63:56]}) ^ {v[61:0], v[63:62]};
  endfunction

  function automatic logic [63:0] t_key(input logic [63:0] k);
    return {k[2:0], k[63:3]} ^ {k[3:0], k[63:4]};
  endfunction

  // Index wraps modulo 62; out-of-range (only the don't-care i<2 case) yields 0.
  function automatic logic z_bit(input logic [6:0] idx_in);
    logic [6:0] idx;
    idx = idx_in;
    if (idx >= 7'd62) begin
      idx = idx - 7'd62;
    end else begin
      idx = idx;
    end
    if (idx > 7'd61) begin
      return 1'b0;
    end else begin
      return Z2[7'd61 - idx];
    end
  endfunction

  // Round and key-schedule datapath shared by all states.
  always_comb begin
    enc_x = y ^ f_round(x) ^ ka;
    dec_y = x ^ f_round(y) ^ kb;
    k_fwd = C ^ {63'd0, z_bit(i)} ^ ka ^ t_key(kb);
    k_inv = C ^ {63'd0, z_bit(i - 7'd2)} ^ kb ^ t_key(ka);
  end

  // Control FSM, round state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      i       <= 7'd0;
      x       <= 64'd0;
      y       <= 64'd0;
      ka      <= 64'd0;
      kb      <= 64'd0;
      valid_o <= 1'b0;
      ct_o    <= 128'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            x       <= pt_i[127:64];
            y       <= pt_i[63:0];
            ka      <= k0_i[63:0];
            kb      <= k0_i[127:64];
            i       <= 7'd0;
            valid_o <= 1'b0;
            state   <= encrypt_i ? ENC : KEXP;
          end else begin
            state <= state;
          end
        end
        ENC: begin
          x  <= enc_x;
          y  <= x;
          ka <= kb;
          kb <= k_fwd;
          i  <= i + 7'd1;
          if (i == LAST) begin
            state   <= DONE;
            valid_o <= 1'b1;
            ct_o    <= {enc_x, x};
          end else begin
            state <= ENC;
          end
        end
        KEXP: begin
          ka <= kb;
          kb <= k_fwd;
          if (i == KLAST) begin
            state <= DEC;
            i     <= LAST;
          end else begin
            state <= KEXP;
            i     <= i + 7'd1;
          end
        end
        DEC: begin
          // kb holds k(i); ka steps back to k(i-2).
          x  <= y;
          y  <= dec_y;
          kb <= ka;
          ka <= k_inv;
          i  <= i - 7'd1;
          if (i == 7'd0) begin
            state   <= DONE;
            valid_o <= 1'b1;
            ct_o    <= {y, dec_y};
          end else begin
            state <= DEC;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_engine.sv
// Self-checking bench for simon_round_engine: KAT table, multi-cycle corner
// sequences and a random round-trip against a software Simon 128/128 model.
module tb_simon_round_engine;

  localparam logic [127:0] KEY    = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KAT_PT = 128'h6373656420737265_6c6c657661727420;
  localparam logic [127:0] KAT_CT = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
  localparam int BUDGET = 300;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         encrypt_i;
  logic [127:0] pt_i;
  logic [127:0] k0_i;
  logic         valid_o;
  logic [127:0] ct_o;

  int checks = 0;
  int errors = 0;

  simon_round_engine #(.NR(68)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .encrypt_i(encrypt_i),
    .pt_i(pt_i), .k0_i(k0_i), .valid_o(valid_o), .ct_o(ct_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         enc;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] exp_ct;
    int           exp_lat;
  } vec_t;

  function automatic logic [63:0] rol(input logic [63:0] v, input int j);
    return (v << j) | (v >> (64 - j));
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int j);
    return (v >> j) | (v << (64 - j));
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [63:0] k [0:67];
    logic [61:0] z2;
    logic [63:0] x, y, tmp;
    z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int n = 0; n < 66; n++) begin
      k[n+2] = 64'hFFFF_FFFF_FFFF_FFFC ^ {63'd0, z2[61 - (n % 62)]} ^ k[n]
               ^ ror(k[n+1], 3) ^ ror(k[n+1], 4);
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int n = 0; n < 68; n++) begin
      tmp = x;
      x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[n];
      y = tmp;
    end
    return {x, y};
  endfunction

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Caller is at a negedge; start is presented for exactly one rising edge (E0).
  task automatic start_op(input logic enc, input logic [127:0] pt, input logic [127:0] key);
    start_i   = 1'b1;
    encrypt_i = enc;
    pt_i      = pt;
    k0_i      = key;
    @(negedge clk);
    start_i   = 1'b0;
    encrypt_i = ~enc;
    pt_i      = ~pt;
    k0_i      = ~key;
  endtask

  // Counts rising edges after E0 until valid_o is seen; expiry returns BUDGET.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    vec_t vecs [4];
    int lat;
    logic [127:0] rpt, rkey, rexp;

    vecs[0] = '{1'b1, KAT_PT, KEY, KAT_CT, 68};
    vecs[1] = '{1'b0, KAT_CT, KEY, KAT_PT, 134};
    vecs[2] = '{1'b0, KAT_CT, KEY, KAT_PT, 134};
    vecs[3] = '{1'b1, KAT_PT, KEY, KAT_CT, 68};

    rst_n = 1'b0; start_i = 1'b0; encrypt_i = 1'b0; pt_i = '0; k0_i = '0;
    repeat (3) @(negedge clk);
    chkint("reset_valid", int'(valid_o), 0);
    chk128("reset_ct", ct_o, 128'd0);
    chk128("model_kat", model_enc(KAT_PT, KEY), KAT_CT);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer table; consecutive entries also exercise restart from DONE.
    for (int v = 0; v < 4; v++) begin
      start_op(vecs[v].enc, vecs[v].pt, vecs[v].key);
      chkint($sformatf("vec%0d_valid_low", v), int'(valid_o), 0);
      wait_valid(lat);
      chkint($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      chk128($sformatf("vec%0d_ct", v), ct_o, vecs[v].exp_ct);
      @(negedge clk);
    end

    // Busy-start immunity: a decrypt start of zero at cycle 30 must be ignored.
    start_op(1'b1, KAT_PT, KEY);
    lat = 0;
    while (!valid_o && lat < BUDGET) begin
      @(negedge clk);
      lat++;
      if (lat == 30) begin
        start_i = 1'b1; encrypt_i = 1'b0; pt_i = '0;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    chkint("busy_latency", lat, 68);
    chk128("busy_ct", ct_o, KAT_CT);
    @(negedge clk);

    // Reset in the middle of a decrypt aborts it.
    start_op(1'b0, KAT_CT, KEY);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chkint("midreset_valid", int'(valid_o), 0);
    chk128("midreset_ct", ct_o, 128'd0);
    start_op(1'b1, KAT_PT, KEY);
    wait_valid(lat);
    chkint("after_reset_latency", lat, 68);
    chk128("after_reset_ct", ct_o, KAT_CT);

    // Sticky valid through idle cycles, then decrypt of the result.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chkint($sformatf("sticky_valid_%0d", c), int'(valid_o), 1);
      chk128($sformatf("sticky_ct_%0d", c), ct_o, KAT_CT);
    end
    @(negedge clk);
    start_op(1'b0, KAT_CT, KEY);
    chkint("restart_valid_drop", int'(valid_o), 0);
    chk128("restart_ct_hold", ct_o, KAT_CT);
    wait_valid(lat);
    chkint("restart_latency", lat, 134);
    chk128("restart_pt", ct_o, KAT_PT);

    // Random round-trip; decrypt starts in the first DONE cycle (no bubble).
    for (int r = 0; r < 200; r++) begin
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rexp = model_enc(rpt, rkey);
      start_op(1'b1, rpt, rkey);
      wait_valid(lat);
      chkint($sformatf("rnd%0d_enc_latency", r), lat, 68);
      chk128($sformatf("rnd%0d_enc_ct", r), ct_o, rexp);
      start_op(1'b0, rexp, rkey);
      wait_valid(lat);
      chkint($sformatf("rnd%0d_dec_latency", r), lat, 134);
      chk128($sformatf("rnd%0d_dec_pt", r), ct_o, rpt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_round_engine.md
# simon_round_engine

- Iterative Simon 128/128 block-cipher engine: one round and one key-schedule step per clock.
- Sits directly downstream of the memory-mapped Simon bus interface, which supplies these inputs from its registers:
  - plaintext or ciphertext;
  - 128-bit key;
  - mode;
  - a one-cycle start pulse.
- The bus interface reads `ct_o` and `valid_o` back through its register map.
- Encryption and decryption use the same datapath; decryption first runs the key schedule forward, then unwinds it.

## Interface
- `NR`, default 68: number of rounds. Only 68 is production-legal; 3..68 is allowed for reduced-round debug.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  start pulse, sampled only in IDLE or DONE.
- `encrypt_i`  in  1  mode: 1 = encrypt, 0 = decrypt. Sampled with `start_i`.
- `pt_i`  in  128  input block: `{x,y}`, where `x = pt_i[127:64]` and `y = pt_i[63:0]`. Holds ciphertext when decrypting.
- `k0_i`  in  128  key: `k0 = k0_i[63:0]`, `k1 = k0_i[127:64]`.
- `valid_o`  out  1  result ready. Sticky until the next accepted start or reset.
- `ct_o`  out  128  result block `{x,y}`. Holds its value between completions.

## Operation
- **Notation:** `S^j` = 64-bit rotate-left by j; `S^-j` = rotate-right by j.
- **Round function:** `f(v) = (S^1 v & S^8 v) ^ S^2 v`.
- **Key-schedule helper:** `t(k) = S^-3 k ^ S^-4 k`, i.e. `S^-1(S^-3 k) ^ S^-3 k`.
- **Constants:**
  - `c = 64'hFFFF_FFFF_FFFF_FFFC`.
  - z2 sequence, index 0 = leftmost: `10101111011100000011010010011000101000010001111110010110110011`.
  - `z(i) = z2[i mod 62]`, applied at bit 0.
- **Forward key schedule:** `k(i+2) = c ^ z(i) ^ k(i) ^ t(k(i+1))`.
- **Inverse key schedule:** `k(i) = c ^ z(i) ^ k(i+2) ^ t(k(i+1))`.
- **Registers:** `x`, `y`, `ka`, `kb` (64 bits each); a round counter `i` (7 bits); `state`; `valid_o`; `ct_o`.
- **States:** IDLE, KEXP, ENC, DEC, DONE.
- **IDLE/DONE, `start_i=1`:**
  - Load `x,y` from `pt_i`; load `ka=k0`, `kb=k1`; set `i=0`; clear `valid_o`.
  - Go to ENC if `encrypt_i=1`, else KEXP.
  - With `start_i=0`, hold.
- **ENC**, per cycle:
  - `x <= y ^ f(x) ^ ka`; `y <= x`.
  - `ka <= kb`; `kb <= c ^ z(i) ^ ka ^ t(kb)`; `i <= i+1`.
  - On the cycle with `i = NR-1`: go to DONE, set `valid_o=1`, and load `ct_o` with the new `{x,y}`.
- **KEXP**, per cycle:
  - `ka <= kb`; `kb <= c ^ z(i) ^ ka ^ t(kb)`; `i <= i+1`.
  - On the cycle with `i = NR-3`: go to DEC and set `i <= NR-1`. Now `ka = k(NR-2)` and `kb = k(NR-1)`.
- **DEC**, per cycle, with `kb = k(i)`:
  - `x <= y`; `y <= x ^ f(y) ^ kb`.
  - `kb <= ka`; `ka <= c ^ z(i-2) ^ kb ^ t(ka)`. This update is don't-care when `i < 2`.
  - `i <= i-1`.
  - On the cycle with `i = 0`: go to DONE, set `valid_o=1`, and load `ct_o`.
- **`start_i` while in KEXP/ENC/DEC:** ignored; the operation continues unchanged.
- **`pt_i`, `k0_i`, `encrypt_i`:** sampled only on the accepting edge and may change afterwards.

## Timing
- **Reset** (`rst_n=0` at a rising edge) has priority over everything:
  - `state = IDLE`, `valid_o = 0`, `ct_o = 0`, `i = 0`, `x = y = ka = kb = 0`.
  - Reset mid-operation aborts the operation; `valid_o` stays 0.
- **Start edge:** call the edge that accepts `start_i` E0.
- **Encrypt:** rounds occur on E1..E(NR). `valid_o=1` and `ct_o` are valid after E(NR), i.e. 68 cycles for NR=68.
- **Decrypt:**
  - Key expansion on E1..E(NR-2).
  - Rounds on E(NR-1)..E(2NR-2).
  - `valid_o` rises after E(2NR-2), i.e. 134 cycles for NR=68.
- **Restart from DONE:**
  - `valid_o` falls on the accepting edge.
  - `ct_o` keeps the previous result until the new completion edge.
- **Back-to-back:** a `start_i` presented in the first DONE cycle is accepted; the next operation begins with no bubble.
- **No combinational paths:** none from inputs to outputs; all outputs are registered.

## Test plan
- **Encrypt known answer:**
  - Stimulus: `k0_i = 0f0e0d0c0b0a0908_0706050403020100`, `pt_i = 6373656420737265_6c6c657661727420`, `encrypt_i=1`, one-cycle start.
  - Required: `ct_o = 49681b1e1e54fe3f_65aa832af84e0bbc`, with `valid_o` rising exactly 68 cycles after the start edge.
- **Decrypt known answer:**
  - Stimulus: same key, `pt_i = 49681b1e1e54fe3f_65aa832af84e0bbc`, `encrypt_i=0`.
  - Required: `ct_o = 6373656420737265_6c6c657661727420`, with `valid_o` rising 134 cycles after the start edge.
- **Busy-start immunity:**
  - Stimulus: during the encrypt above, pulse `start_i` at cycle 30 with `encrypt_i=0` and `pt_i = 0`.
  - Required: result and latency unchanged (KAT ciphertext at cycle 68).
- **Reset mid-operation:**
  - Stimulus: assert `rst_n=0` for 1 cycle at cycle 50 of a decrypt.
  - Required: next cycle shows `valid_o=0` and `ct_o=0`; a fresh encrypt start afterwards yields the KAT result at +68.
- **Back-to-back and sticky valid:**
  - Stimulus: encrypt to DONE; leave idle for 10 cycles; then start a decrypt of the result in the first cycle after that.
  - Required: `valid_o` stays 1 and `ct_o` stays stable during the idle cycles; `valid_o` drops on the start edge; original plaintext returns at +134.
- **Random round-trip:**
  - Stimulus: 200 random key/block pairs; encrypt, then decrypt the output.
  - Required: the original block is returned, and every `ct_o` matches a software Simon 128/128 model.
